// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
//
// Front end of the SPI register path. The three asynchronous SPI pins are
// synchronized into the clk domain. Edges are detected on the synchronized
// sclk and ncs. Mode-0, MSB-first frames of 1 + ADDR_W + DATA_W bits are then
// deserialized. A well-formed frame is presented as {rw, addr, data} with a
// one-cycle frame_valid strobe. A frame that closes with the wrong bit count
// produces a one-cycle frame_err strobe instead, so the downstream register
// decoder never commits a partial write.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sclk         SPI clock pin (asynchronous)
//   copi         SPI data-in pin (asynchronous)
//   ncs          SPI chip select pin, active low (asynchronous)
//   frame_valid  one-cycle pulse: complete well-formed frame on frame_*
//   frame_err    one-cycle pulse: frame closed with bit count != FRAME_BITS
//   frame_rw     frame MSB (1 = write, 0 = read)
//   frame_addr   address field of the last valid frame
//   frame_data   data field of the last valid frame
//   busy         high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              frame_valid,
  output logic              frame_err,
  output logic              frame_rw,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              busy
);

  localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge history
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_hist, ncs_hist;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  // The ncs chain clears to 0 (not to the idle-high pin level). Reset released
  // with ncs already low then shows no falling edge, so a frame in progress is
  // never entered part-way. Reset released with ncs high shows a rising edge
  // in IDLE, which the state machine ignores.
  // NOTE: sequential state is written with non-blocking (<=) assignments only,
  // so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '0;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_s;
      ncs_hist  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;

  // ---------------------------------------------------------------------------
  // Frame state machine and datapath
  // ---------------------------------------------------------------------------
  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]        bit_cnt, cnt_next;
  logic                    overrun, overrun_next;
  logic                    valid_next, err_next;
  logic                    rw_next;
  logic [ADDR_W-1:0]       addr_next;
  logic [DATA_W-1:0]       data_next;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    cnt_next     = bit_cnt;
    overrun_next = overrun;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    rw_next      = frame_rw;
    addr_next    = frame_addr;
    data_next    = frame_data;

    case (state)
      IDLE: begin
        // sclk activity with the chip deselected is ignored.
        if (ncs_fall) begin
          state_next   = SHIFT;
          shift_next   = '0;
          cnt_next     = '0;
          overrun_next = 1'b0;
        end
      end

      SHIFT: begin
        // ncs rise takes priority: an sclk rise seen in the same cycle is
        // dropped and neither shifts nor counts as an overrun.
        if (ncs_rise) begin
          state_next = IDLE;
          if (bit_cnt == FRAME_CNT && !overrun) begin
            valid_next = 1'b1;
            rw_next    = shift_reg[FRAME_BITS-1];
            addr_next  = shift_reg[FRAME_BITS-2 -: ADDR_W];
            data_next  = shift_reg[DATA_W-1:0];
          end else begin
            err_next = 1'b1;
          end
        end else if (sclk_rise) begin
          if (bit_cnt < FRAME_CNT) begin
            shift_next = {shift_reg[FRAME_BITS-2:0], copi_s};
            cnt_next   = bit_cnt + CNT_W'(1);
          end else begin
            // Extra clocks beyond a full frame freeze the data and poison it.
            overrun_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: the shift register and output fields are reset along with the
  // control state, so a reset mid-frame leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      overrun     <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_rw    <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      bit_cnt     <= cnt_next;
      overrun     <= overrun_next;
      frame_valid <= valid_next;
      frame_err   <= err_next;
      frame_rw    <= rw_next;
      frame_addr  <= addr_next;
      frame_data  <= data_next;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
//
// Self-checking bench for spi_frame_receiver at default parameters. It
// drives the SPI pins on falling clk edges and samples the DUT 1 ns after
// rising edges. A table of frames covers the basic cases, hand sequences
// cover the multi-cycle corners, and random frames are checked against a
// frame-level model: a frame of exactly 16 bits replaces the expected
// fields, and any other length leaves them and raises an error pulse.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;

  localparam int NBITS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, copi, ncs;
  logic       frame_valid, frame_err, frame_rw, busy;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  spi_frame_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .copi        (copi),
    .ncs         (ncs),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_rw    (frame_rw),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pulse monitor: counts strobes, logs valid frames, flags protocol breaks.
  // ---------------------------------------------------------------------------
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  int          viol      = 0;
  logic        prev_v    = 1'b0;
  logic        prev_e    = 1'b0;
  logic [15:0] got_q[$];

  always @(posedge clk) begin
    #1;
    if (frame_valid && frame_err) viol++;
    if ((frame_valid && prev_v) || (frame_err && prev_e)) viol++;
    prev_v = frame_valid;
    prev_e = frame_err;
    if (frame_valid) begin
      valid_cnt++;
      got_q.push_back({frame_rw, frame_addr, frame_data});
    end
    if (frame_err) err_cnt++;
  end

  // Frame-level reference: the fields the DUT should currently hold.
  logic [15:0] m_fields = '0;

  function automatic logic [15:0] dut_fields();
    return {frame_rw, frame_addr, frame_data};
  endfunction

  function automatic logic frame_bit(input logic [15:0] word, input int i);
    return (i < NBITS) ? word[NBITS-1-i] : 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Pin-level helpers. Each is entered and left on a falling clk edge.
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic b, input int phase);
    copi = b;
    repeat (phase) @(negedge clk);
    sclk = 1'b1;
    repeat (phase) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic start_frame(input int phase);
    ncs = 1'b0;
    repeat (phase) @(negedge clk);
  endtask

  // Raise ncs and expect exactly the given pulses on the third rising edge.
  task automatic close_frame(input logic ev, input logic ee);
    logic [3:0] v_hist, e_hist;
    ncs = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      v_hist[k] = frame_valid;
      e_hist[k] = frame_err;
    end
    check("valid_timing", {28'd0, v_hist}, {28'd0, 1'b0, ev, 2'b00});
    check("err_timing",   {28'd0, e_hist}, {28'd0, 1'b0, ee, 2'b00});
    check("busy_after_close", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] word, input int nbits, input int phase,
                           input logic ev, input logic ee, input logic [15:0] exp_fields);
    @(negedge clk);
    start_frame(phase);
    for (int i = 0; i < nbits; i++) begin
      send_bit(frame_bit(word, i), phase);
      if (i == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
    end
    repeat (phase) @(negedge clk);
    close_frame(ev, ee);
    check("fields", {16'd0, dut_fields()}, {16'd0, exp_fields});
    if (nbits == NBITS) m_fields = word;
  endtask

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic        ev;
    logic        ee;
    logic [15:0] fields;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int v0, e0, n0;

    vecs[0] = '{word: 16'h84A5, nbits: 16, ev: 1'b1, ee: 1'b0, fields: 16'h84A5};
    vecs[1] = '{word: 16'h84A5, nbits: 15, ev: 1'b0, ee: 1'b1, fields: 16'h84A5};
    vecs[2] = '{word: 16'h84A5, nbits: 17, ev: 1'b0, ee: 1'b1, fields: 16'h84A5};
    vecs[3] = '{word: 16'h0310, nbits: 16, ev: 1'b1, ee: 1'b0, fields: 16'h0310};

    // Reset with the pins idle; ncs high at release must be ignored.
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {16'd0, frame_valid, frame_err, frame_rw, frame_addr, frame_data, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("release_no_valid", valid_cnt, 0);
    check("release_no_err",   err_cnt, 0);
    check("release_idle",     {31'd0, busy}, 32'd0);

    // sclk pulses with ncs deselected do nothing.
    for (int i = 0; i < 8; i++) begin
      send_bit(i[0], 4);
      check("deselected_busy", {31'd0, busy}, 32'd0);
    end
    repeat (4) @(negedge clk);
    check("deselected_no_valid", valid_cnt, 0);
    check("deselected_no_err",   err_cnt, 0);

    // Table-driven frames.
    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].word, vecs[i].nbits, 4, vecs[i].ev, vecs[i].ee, vecs[i].fields);

    // Asynchronous reset mid-frame, released with ncs still low.
    @(negedge clk);
    start_frame(4);
    for (int i = 0; i < 8; i++) send_bit(frame_bit(16'h84A5, i), 4);
    check("pre_reset_busy",   {31'd0, busy}, 32'd1);
    check("pre_reset_fields", {16'd0, dut_fields()}, 32'h0310);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {16'd0, frame_valid, frame_err, frame_rw, frame_addr, frame_data, busy}, 32'd0);
    m_fields = '0;
    v0 = valid_cnt;
    e0 = err_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 8; i < 16; i++) begin
      send_bit(frame_bit(16'h84A5, i), 4);
      check("aborted_busy", {31'd0, busy}, 32'd0);
    end
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (8) @(negedge clk);
    check("aborted_no_valid", valid_cnt, v0);
    check("aborted_no_err",   err_cnt, e0);
    check("aborted_fields",   {16'd0, dut_fields()}, 32'd0);
    run_frame(16'h8001, 16, 4, 1'b1, 1'b0, 16'h8001);

    // Back-to-back frames with ncs high for exactly two clk periods.
    n0 = got_q.size();
    @(negedge clk);
    start_frame(4);
    for (int i = 0; i < 16; i++) send_bit(frame_bit(16'h8001, i), 4);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(4);
    for (int i = 0; i < 16; i++) send_bit(frame_bit(16'h81FF, i), 4);
    repeat (4) @(negedge clk);
    close_frame(1'b1, 1'b0);
    check("b2b_count", got_q.size(), n0 + 2);
    if (got_q.size() >= n0 + 2) begin
      check("b2b_first",  {16'd0, got_q[n0]},     32'h8001);
      check("b2b_second", {16'd0, got_q[n0 + 1]}, 32'h81FF);
    end
    m_fields = 16'h81FF;

    // 16th sclk rise and ncs rise at the pins together: ncs wins, 15 bits.
    v0 = valid_cnt;
    @(negedge clk);
    start_frame(4);
    for (int i = 0; i < 15; i++) send_bit(frame_bit(16'h84A5, i), 4);
    copi = frame_bit(16'h84A5, 15);
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    close_frame(1'b0, 1'b1);
    @(negedge clk);
    sclk = 1'b0;
    check("race_no_valid", valid_cnt, v0);
    check("race_fields",   {16'd0, dut_fields()}, {16'd0, m_fields});

    // Random frames against the frame-level model.
    for (int n = 0; n < 24; n++) begin
      logic [15:0] word;
      int          nbits, phase;
      logic        ok;
      word  = 16'($urandom);
      nbits = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(0, 20));
      phase = int'($urandom_range(2, 5));
      ok    = (nbits == NBITS);
      run_frame(word, nbits, phase, ok, !ok, ok ? word : m_fields);
    end

    repeat (4) @(negedge clk);
    check("pulse_protocol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Front-end stage directly upstream of the SPI register decode that drives the PWM enable and duty-cycle registers.
- Synchronizes the asynchronous SPI pins (sclk, copi, ncs) into the system clock domain, detects edges, and deserializes mode-0, MSB-first 16-bit frames.
- Presents each complete frame as parallel {rw, addr, data} with a one-cycle valid strobe.
- Flags malformed frames with a one-cycle error strobe so the decoder never commits a partial write.

Parameters:
SYNC_STAGES, 2, flops per synchronizer chain on sclk/copi/ncs (minimum 2)
ADDR_W, 7, address field width
DATA_W, 8, data field width; FRAME_BITS = 1 + ADDR_W + DATA_W (16 at defaults)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock pin (ui_in[0]), asynchronous
copi  input  1  SPI data-in pin (ui_in[1]), asynchronous
ncs  input  1  SPI chip select pin (ui_in[2]), active low, asynchronous
frame_valid  output  1  one-cycle pulse: complete well-formed frame available
frame_err  output  1  one-cycle pulse: frame ended with bit count != FRAME_BITS
frame_rw  output  1  frame bit 15 (1 = write, 0 = read)
frame_addr  output  ADDR_W  frame bits 14:8
frame_data  output  DATA_W  frame bits 7:0
busy  output  1  high while a frame is in progress (state SHIFT)

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state clears immediately on rst_n low, independent of clk.
- Reset values: all outputs 0. All synchronizer flops and edge-history flops 0, including the ncs chain.
  - ncs low at reset release produces no falling edge, so a frame already in progress is never entered mid-way.
  - ncs high at reset release produces a rising edge in IDLE, which is ignored.
- Synchronization: each pin passes through SYNC_STAGES flops (sclk_s, copi_s, ncs_s). One further history flop per sclk and ncs supports edge detection.
  - Rise = s & ~hist; fall = ~s & hist.
- Latency: pin edge to internal edge detection is SYNC_STAGES clk edges. Registered outputs update on the following edge, so ncs pin rise to frame_valid/frame_err high is SYNC_STAGES+1 clk edges.
- Input timing requirement: sclk high and low phases each >= 2 clk periods; ncs high >= 2 clk periods between frames. Behaviour outside these limits is undefined.
- State machine:
  - IDLE:
    - ncs fall -> SHIFT; shift register cleared; bit_cnt cleared; overrun cleared.
    - sclk edges ignored.
  - SHIFT, on sclk rise:
    - If bit_cnt < FRAME_BITS: shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s}; bit_cnt increments.
    - Otherwise: shift_reg frozen; overrun set.
  - SHIFT, on ncs rise -> IDLE:
    - If bit_cnt == FRAME_BITS and no overrun: frame_valid = 1 for one cycle; frame_rw/addr/data load from shift_reg in the same edge.
    - Otherwise: frame_err = 1 for one cycle; frame_* fields unchanged.
  - sclk falling edges have no effect in any state.
- bit_cnt width: clog2(FRAME_BITS+1); saturates at FRAME_BITS.
- Simultaneous ncs rise and sclk rise in the same cycle: ncs rise wins; the sclk edge is discarded, so it neither shifts nor sets overrun.
- frame_rw/addr/data hold the last valid frame until the next valid frame or reset.
- frame_valid and frame_err are never high together and never high for more than one cycle.
- busy = (state == SHIFT); it deasserts on the same edge as the frame_valid/frame_err pulse.
- Reset asserted mid-frame aborts the frame. No pulse is produced, including when ncs later rises for the aborted frame.

Test Plan:
1. Write frame 0x84A5 (16 sclk pulses, 4 clk per phase) -> busy high during frame. frame_valid high exactly one cycle, 3 clk edges after ncs pin rise. frame_rw=1, frame_addr=0x04, frame_data=0xA5, frame_err=0.
2. After test 1, 15-bit frame -> frame_err one-cycle pulse, frame_valid stays 0, fields remain 1/0x04/0xA5. Then 17-bit frame -> frame_err pulse again, fields unchanged.
3. 8 sclk pulses with ncs held high -> no pulses, busy 0. Then frame 0x0310 -> frame_valid; rw=0, addr=0x03, data=0x10.
4. Assert rst_n after 8 bits of frame 0x84A5 -> all outputs 0 immediately, without a clk edge. Release with ncs still low, clock remaining 8 bits, raise ncs -> no frame_valid, no frame_err. Next full frame 0x8001 -> valid; rw=1, addr=0x00, data=0x01.
5. Back-to-back frames 0x8001 then 0x81FF, ncs high exactly 2 clk between them -> two frame_valid pulses; second gives addr=0x01, data=0xFF.
6. 16th sclk rise and ncs rise reach the pins in the same clk cycle -> ncs wins, bit_cnt=15 at close, frame_err pulse, no frame_valid.
